// File: rtl/spad_rd_seq_if.sv
// Bus bundle for the scratchpad read sequencer.
// It carries the command, the scratchpad read port, the downstream stream and the state debug tap.
interface spad_rd_seq_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
);
  // Command side.
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [LEN_W-1:0]  i_len;
  logic              o_busy;
  logic              o_done;

  // Scratchpad read port. Data returns a fixed latency after o_re.
  logic              o_re;
  logic [ADDR_W-1:0] o_raddr;
  logic [DATA_W-1:0] i_rdata;

  // Downstream stream handshake:
  //   o_valid is high while o_data holds a word.
  //   A word moves on every cycle in which o_valid && i_ready.
  //   While o_valid && !i_ready, o_valid stays high and o_data holds its value.
  //   o_valid never depends combinationally on i_ready.
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;

  // FSM state tap: 0=IDLE, 1=ISSUE, 2=DRAIN, 3=DONE.
  logic [1:0]        dbg_state;

  modport master (
    input  i_start, i_base_addr, i_len, i_rdata, i_ready,
    output o_busy, o_done, o_re, o_raddr, o_valid, o_data, dbg_state
  );

  modport slave (
    output i_start, i_base_addr, i_len, i_rdata, i_ready,
    input  o_busy, o_done, o_re, o_raddr, o_valid, o_data, dbg_state
  );
endinterface

// File: rtl/spad_rd_seq.sv
// Scratchpad read sequencer.
// A start command issues a credit-limited burst of reads to a fixed-latency scratchpad.
// A valid shift line realigns the returning data, and a small FIFO hands the words downstream.
module spad_rd_seq #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  spad_rd_seq_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  inflight_q;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [RD_LAT-1:0] rd_vld;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              issue;
  logic              last_issue;
  logic              push;
  logic              pop;

  // A credit is every word in flight or buffered. A pop frees its credit only on the next cycle,
  // which keeps the issue decision on registered state.
  assign occ        = OCC_W'(inflight_q) + OCC_W'(fifo_cnt);
  assign issue      = (state == ISSUE) && (occ < OCC_W'(FIFO_DEPTH));
  assign last_issue = issue && (issued_q == len_q - LEN_W'(1));
  assign push       = rd_vld[RD_LAT-1];
  assign pop        = bus.o_valid && bus.i_ready;

  assign bus.o_re      = issue;
  assign bus.o_raddr   = issue ? (base_q + ADDR_W'(issued_q)) : '0;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_valid   = (fifo_cnt != '0);
  assign bus.o_data    = fifo_mem[rd_ptr];
  assign bus.dbg_state = state;

  // Control FSM with registered busy/done flags.
  // A zero-length request passes through DRAIN. The empty check there then takes it to DONE,
  // so zero-length bursts share the completion path.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            base_q   <= bus.i_base_addr;
            len_q    <= bus.i_len;
            issued_q <= '0;
            busy_q   <= 1'b1;
            state    <= (bus.i_len == '0) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            issued_q <= issued_q + LEN_W'(1);
          end
          if (last_issue) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((inflight_q == '0) && (fifo_cnt == '0)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-valid shift line. Its last stage marks the cycle in which i_rdata carries a word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_vld <= '0;
    end else begin
      rd_vld[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld[i] <= rd_vld[i-1];
      end
    end
  end

  // Words in flight: incremented on issue, decremented on write. Both together leave it unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight_q <= '0;
    end else begin
      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Output FIFO storage, pointers and occupancy. The head is read straight from storage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.i_rdata;
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
endmodule
